// File: rtl/data_access.sv
// RV32I load/store unit: turns one pipeline memory request into a single AXI4 read or write beat
// and reports the formatted result, stalling the pipeline while the access is in flight.
`timescale 1ns/1ps
module data_access #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ_VALID,
    input  logic                          REQ_WRITE,
    input  logic [2:0]                    REQ_FUNCT3,
    input  logic [31:0]                   REQ_ADDR,
    input  logic [31:0]                   REQ_WDATA,
    input  logic [4:0]                    REQ_RD,
    output logic                          MEM_WAIT,
    output logic                          RSP_VALID,
    output logic [4:0]                    RSP_RD,
    output logic [31:0]                   RSP_DATA,
    output logic                          RSP_ERR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]                    lane_reg;
    logic [2:0]                    funct3_reg;
    logic [4:0]                    rd_reg;
    logic [31:0]                   data_reg;
    logic                          err_reg;
    logic                          aw_done_reg;
    logic                          w_done_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_reg;
    logic [3:0]                    wstrb_reg;

    logic        misaligned;
    logic [31:0] store_data;
    logic [3:0]  store_strb;
    logic [31:0] rdata_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        aw_ok;
    logic        w_ok;

    // Unsupported funct3 encodings fold into the misaligned error path.
    always_comb begin
        misaligned = 1'b1;
        case (REQ_FUNCT3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = REQ_ADDR[0];
            3'b010:         misaligned = |REQ_ADDR[1:0];
            default:        misaligned = 1'b1;
        endcase
    end

    // Each byte lane picks its source byte from the store size; strobes follow the lane address.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign store_data[8*gi +: 8] = (REQ_FUNCT3[1:0] == 2'b00) ? REQ_WDATA[7:0] :
                                       (REQ_FUNCT3[1:0] == 2'b01) ? REQ_WDATA[8*(gi%2) +: 8] :
                                                                    REQ_WDATA[8*gi +: 8];
        assign store_strb[gi] = (REQ_FUNCT3[1:0] == 2'b00) ? (REQ_ADDR[1:0] == 2'(gi)) :
                                (REQ_FUNCT3[1:0] == 2'b01) ? (REQ_ADDR[1] == 1'(gi / 2)) :
                                                             1'b1;
    end

    assign rdata_word = M_AXI_RDATA[31:0];
    assign load_byte  = rdata_word[{lane_reg, 3'b000} +: 8];
    assign load_half  = rdata_word[{lane_reg[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata_word;
        case (funct3_reg)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = rdata_word;
        endcase
    end

    // A channel counts as accepted if it handshook earlier or is handshaking now.
    assign aw_ok = aw_done_reg | M_AXI_AWREADY;
    assign w_ok  = w_done_reg | M_AXI_WREADY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (REQ_VALID) begin
                    if (misaligned)     state_next = DONE;
                    else if (REQ_WRITE) state_next = WR_REQ;
                    else                state_next = RD_ADDR;
                end
            end
            RD_ADDR: if (M_AXI_ARREADY) state_next = RD_DATA;
            RD_DATA: if (M_AXI_RVALID) state_next = DONE;
            WR_REQ:  if (aw_ok && w_ok) state_next = WR_RESP;
            WR_RESP: if (M_AXI_BVALID) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane_reg    <= '0;
            funct3_reg  <= '0;
            rd_reg      <= '0;
            data_reg    <= '0;
            err_reg     <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            araddr_reg  <= '0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (REQ_VALID) begin
                        lane_reg    <= REQ_ADDR[1:0];
                        funct3_reg  <= REQ_FUNCT3;
                        rd_reg      <= REQ_RD;
                        data_reg    <= '0;
                        err_reg     <= misaligned;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        if (!misaligned) begin
                            if (REQ_WRITE) begin
                                awaddr_reg <= C_M_AXI_ADDR_WIDTH'({REQ_ADDR[31:2], 2'b00});
                                wdata_reg  <= C_M_AXI_DATA_WIDTH'(store_data);
                                wstrb_reg  <= store_strb;
                            end else begin
                                araddr_reg <= C_M_AXI_ADDR_WIDTH'({REQ_ADDR[31:2], 2'b00});
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        err_reg  <= (M_AXI_RRESP != 2'b00);
                        data_reg <= (M_AXI_RRESP != 2'b00) ? 32'd0 : load_data;
                    end
                end
                WR_REQ: begin
                    if (M_AXI_AWREADY) aw_done_reg <= 1'b1;
                    if (M_AXI_WREADY)  w_done_reg  <= 1'b1;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) err_reg <= (M_AXI_BRESP != 2'b00);
                end
                default: ;
            endcase
        end
    end

    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARVALID = (state_reg == RD_ADDR);
    assign M_AXI_RREADY  = (state_reg == RD_DATA);
    assign M_AXI_AWADDR  = awaddr_reg;
    assign M_AXI_AWVALID = (state_reg == WR_REQ) && !aw_done_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = wstrb_reg;
    assign M_AXI_WVALID  = (state_reg == WR_REQ) && !w_done_reg;
    assign M_AXI_WLAST   = M_AXI_WVALID;
    assign M_AXI_BREADY  = (state_reg == WR_RESP);

    // Response fields are only presented during the single DONE cycle.
    assign RSP_VALID = (state_reg == DONE);
    assign RSP_RD    = RSP_VALID ? rd_reg : 5'd0;
    assign RSP_DATA  = RSP_VALID ? data_reg : 32'd0;
    assign RSP_ERR   = RSP_VALID && err_reg;

    assign MEM_WAIT = ((state_reg == IDLE) && REQ_VALID) ||
                      (state_reg == RD_ADDR) || (state_reg == RD_DATA) ||
                      (state_reg == WR_REQ)  || (state_reg == WR_RESP);

endmodule

// File: doc/data_access.md
DATA_ACCESS -- requirements
Module: data_access

Interface
REQ-001 Parameters SHALL be: C_M_AXI_ADDR_WIDTH, default 32, AXI address width; C_M_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset. Ports:
- CLK  in  1  clock
- RST  in  1  async reset, active high
- REQ_VALID  in  1  load/store request present
- REQ_WRITE  in  1  1=store, 0=load
- REQ_FUNCT3  in  3  RV32I funct3 (size/sign)
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data (rs2)
- REQ_RD  in  5  load destination register
- MEM_WAIT  out  1  pipeline stall request
- RSP_VALID  out  1  access complete pulse
- RSP_RD  out  5  destination register of completed access
- RSP_DATA  out  32  formatted load data
- RSP_ERR  out  1  misaligned or bus error
- M_AXI_ARADDR out 32; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1
- M_AXI_AWADDR out 32; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WLAST out 1; M_AXI_WVALID out 1; M_AXI_WREADY in 1
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
REQ-003 Constant AXI fields (LEN=0, SIZE=010, BURST=01, IDs, CACHE, PROT) SHALL remain tied in core; this block drives only the signals above.

Function
REQ-004 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-005 IDLE: REQ_VALID=1 SHALL latch addr/funct3/wdata/rd/write; load -> RD_ADDR, store -> WR_REQ, misaligned -> DONE with RSP_ERR=1 and no bus transaction.
REQ-006 Misaligned SHALL mean halfword (funct3[1:0]=01) with addr[0]=1, or word (10) with addr[1:0]!=00; funct3 011/110/111 SHALL be treated as misaligned (error).
REQ-007 Bus addresses SHALL be word-aligned: {addr[31:2],2'b00}.
REQ-008 RD_ADDR: ARVALID=1 until ARREADY sampled high, then RD_DATA; ARADDR stable while ARVALID=1.
REQ-009 RD_DATA: RREADY=1; on RVALID capture formatted data, RSP_ERR=(RRESP!=00), -> DONE.
REQ-010 Load format: lane = addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
REQ-011 WR_REQ: AWVALID and WVALID SHALL assert together; each deasserts independently once its READY is sampled; -> WR_RESP when both accepted (same or different cycles).
REQ-012 Store data: SB replicates byte to all lanes, WSTRB=0001<<addr[1:0]; SH replicates halfword, WSTRB=0011<<addr[1:0]; SW WSTRB=1111; WLAST=1 whenever WVALID=1.
REQ-013 WR_RESP: BREADY=1; on BVALID RSP_ERR=(BRESP!=00), -> DONE.
REQ-014 DONE: RSP_VALID=1 for exactly one cycle with RSP_RD, RSP_DATA (0 for stores and errors), RSP_ERR; -> IDLE unconditionally; REQ_VALID ignored in DONE.
REQ-015 MEM_WAIT SHALL be combinational: 1 when (IDLE and REQ_VALID) or state in {RD_ADDR, RD_DATA, WR_REQ, WR_RESP}; 0 in DONE and in IDLE without request.
REQ-016 Minimum latency request-to-RSP_VALID SHALL be 3 cycles with zero-wait slave (IDLE->RD_ADDR->RD_DATA->DONE); error path 1 cycle (IDLE->DONE).
REQ-017 Load to rd=0 SHALL still perform the bus read; RSP_RD=0 reported.
REQ-018 At most one outstanding transaction; no VALID asserted in IDLE or DONE.

Reset
REQ-019 RST=1 SHALL asynchronously force IDLE; all AXI VALID/READY, MEM_WAIT (except combinational REQ_VALID term), RSP_VALID, RSP_ERR, RSP_RD, RSP_DATA, addresses, WDATA, WSTRB to 0.
REQ-020 Reset mid-transaction SHALL abandon the transaction; no RSP_VALID is generated for it.

Verification
REQ-021 LW addr 0x100, slave RDATA=0xDEADBEEF zero-wait -> ARADDR=0x100, RSP_VALID on 3rd cycle, RSP_DATA=0xDEADBEEF, RSP_ERR=0, MEM_WAIT high 3 cycles.
REQ-022 LB addr 0x103 RDATA=0x80FF_0000; LBU same -> RSP_DATA=0xFFFFFF80 then 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-023 SB addr 0x202 data 0x123456AB, AWREADY 2 cycles before WREADY -> AWADDR=0x200, WDATA=0xABABABAB, WSTRB=0100, WR_RESP only after both accepted, RSP_DATA=0.
REQ-024 LW addr 0x101 -> no ARVALID, RSP_VALID next cycle, RSP_ERR=1; SW with BRESP=10 -> RSP_ERR=1.
REQ-025 Assert RST during RD_DATA with ARREADY=1 already accepted -> all outputs 0 same cycle, no RSP_VALID; next LW completes normally.
